// File: rtl/mii_tx_frame_scheduler.sv
// mii_tx_frame_scheduler: round-robin 64-bit MII TX scheduler with IPG enforcement and underrun abort.
// Define MII_TX_STATS_EN to add frame/abort counters.
module mii_tx_frame_scheduler #(
  parameter int          N_SRC         = 2,
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = 8,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  TERM_CODE     = 8'hFD,
  parameter logic [7:0]  ERROR_CODE    = 8'hFE,
  parameter int          MIN_IPG_BYTES = 12
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic [N_SRC-1:0]            i_req,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_data,
  input  logic [N_SRC-1:0]            i_valid,
  input  logic [N_SRC-1:0]            i_last,
  input  logic [N_SRC*4-1:0]          i_last_nbytes,
  output logic [N_SRC-1:0]            o_ready,
  output logic [N_SRC-1:0]            o_grant,
  output logic [DATA_WIDTH-1:0]       o_tx_data,
  output logic [CTRL_WIDTH-1:0]       o_tx_ctrl,
  output logic                        o_busy,
  output logic                        o_underrun
`ifdef MII_TX_STATS_EN
  ,
  output logic [31:0]                 o_frame_cnt,
  output logic [15:0]                 o_abort_cnt
`endif
);
  localparam int SW      = $clog2(N_SRC);
  localparam int IPG_MAX = MIN_IPG_BYTES + 8;
  localparam int IW      = $clog2(IPG_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, TERM} state_e;

  state_e                 state_q, state_d;
  logic [N_SRC-1:0]       grant_q, grant_d;
  logic [SW-1:0]          src_q, src_d;
  logic [IW-1:0]          ipg_q, ipg_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [CTRL_WIDTH-1:0]  tx_ctrl_q, tx_ctrl_d;
  logic                   underrun_q, underrun_d;
  logic                   frame_inc, abort_inc;
  logic [IW:0]            ipg_sum;
  logic [DATA_WIDTH-1:0]  word;
  logic [3:0]             nb;
  logic                   valid, last, full, found;
  logic [SW-1:0]          pick, cand;

  assign o_ready    = (state_q == DATA) ? grant_q : '0;
  assign o_grant    = grant_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_ctrl  = tx_ctrl_q;
  assign o_busy     = state_q != IDLE;
  assign o_underrun = underrun_q;

  always_comb begin
    word  = '0;
    nb    = '0;
    valid = 1'b0;
    last  = 1'b0;
    for (int s = 0; s < N_SRC; s++)
      if (src_q == SW'(s)) begin
        word  = i_data[s*DATA_WIDTH +: DATA_WIDTH];
        nb    = i_last_nbytes[s*4 +: 4];
        valid = i_valid[s];
        last  = i_last[s];
      end
    full  = (nb == 4'd0) || (nb >= 4'd8);
    found = 1'b0;
    pick  = src_q;
    cand  = src_q;
    // search starts just after the last granted source, wrapping around
    for (int k = 1; k <= N_SRC; k++) begin
      cand = SW'((int'(src_q) + k) % N_SRC);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    ipg_sum    = {1'b0, ipg_q} + (IW+1)'(8);
    state_d    = state_q;
    grant_d    = grant_q;
    src_d      = src_q;
    ipg_d      = ipg_q;
    tx_data_d  = {8{IDLE_CODE}};
    tx_ctrl_d  = '1;
    underrun_d = 1'b0;
    frame_inc  = 1'b0;
    abort_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        ipg_d = (ipg_sum > (IW+1)'(IPG_MAX)) ? IW'(IPG_MAX) : ipg_sum[IW-1:0];
        if (found && ipg_sum >= (IW+1)'(MIN_IPG_BYTES)) begin
          state_d = START;
          src_d   = pick;
          grant_d = N_SRC'(1) << pick;
        end
      end
      START: begin
        tx_data_d = {8'hD5, {6{8'h55}}, START_CODE};
        tx_ctrl_d = CTRL_WIDTH'(8'h01);
        state_d   = DATA;
      end
      DATA: begin
        if (!valid) begin
          tx_data_d  = {8{ERROR_CODE}};
          underrun_d = 1'b1;
          abort_inc  = 1'b1;
          ipg_d      = '0;
          grant_d    = '0;
          state_d    = IDLE;
        end else begin
          tx_data_d = word;
          tx_ctrl_d = '0;
          if (last && full) state_d = TERM;
          else if (last) begin
            // short last word carries TERM in the first unused lane
            for (int l = 0; l < 8; l++)
              if (l == int'(nb[2:0])) tx_data_d[l*8 +: 8] = TERM_CODE;
              else if (l > int'(nb[2:0])) tx_data_d[l*8 +: 8] = IDLE_CODE;
            tx_ctrl_d = CTRL_WIDTH'(8'hFF << nb[2:0]);
            ipg_d     = IW'(3'd7 - nb[2:0]);
            frame_inc = 1'b1;
            grant_d   = '0;
            state_d   = IDLE;
          end
        end
      end
      TERM: begin
        tx_data_d = {{7{IDLE_CODE}}, TERM_CODE};
        ipg_d     = IW'(7);
        frame_inc = 1'b1;
        grant_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      src_q      <= SW'(N_SRC - 1);
      ipg_q      <= IW'(MIN_IPG_BYTES);
      tx_data_q  <= {8{IDLE_CODE}};
      tx_ctrl_q  <= '1;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      src_q      <= src_d;
      ipg_q      <= ipg_d;
      tx_data_q  <= tx_data_d;
      tx_ctrl_q  <= tx_ctrl_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef MII_TX_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 32'(frame_inc);
  assign abort_cnt_d = abort_cnt_q + 16'(abort_inc);
  assign o_frame_cnt = frame_cnt_q;
  assign o_abort_cnt = abort_cnt_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_inc ^ abort_inc;
`endif
endmodule

// File: tb/tb_mii_tx_frame_scheduler.sv
// tb_mii_tx_frame_scheduler: directed checks of framing, IPG, round-robin, underrun and reset.
module tb_mii_tx_frame_scheduler;
  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [1:0]   i_req = '0;
  logic [127:0] i_data = '0;
  logic [1:0]   i_valid = '0;
  logic [1:0]   i_last = '0;
  logic [7:0]   i_last_nbytes = 8'h88;
  logic [1:0]   o_ready, o_grant;
  logic [63:0]  o_tx_data;
  logic [7:0]   o_tx_ctrl;
  logic         o_busy, o_underrun;
`ifdef MII_TX_STATS_EN
  logic [31:0]  frame_cnt;
  logic [15:0]  abort_cnt;
`endif
  int total = 0;
  int bad = 0;
  int wcnt [2] = '{0, 0};
  int len  [2] = '{1, 1};
  int drop [2] = '{-1, -1};

  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = {8{8'hFE}};

  mii_tx_frame_scheduler dut (
`ifdef MII_TX_STATS_EN
    .o_frame_cnt  (frame_cnt),
    .o_abort_cnt  (abort_cnt),
`endif
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .i_last_nbytes(i_last_nbytes),
    .o_ready      (o_ready),
    .o_grant      (o_grant),
    .o_tx_data    (o_tx_data),
    .o_tx_ctrl    (o_tx_ctrl),
    .o_busy       (o_busy),
    .o_underrun   (o_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int s, input int k);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(s*64 + k*8 + l);
    return r;
  endfunction

  function automatic logic [63:0] pat_last(input int s, input int k, input int n);
    logic [63:0] r;
    r = pat(s, k);
    for (int l = 0; l < 8; l++)
      if (l == n) r[l*8 +: 8] = 8'hFD;
      else if (l > n) r[l*8 +: 8] = 8'h07;
    return r;
  endfunction

  // source model: feeds the granted source one word per ready cycle
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++)
      if (o_ready[s]) begin
        i_valid[s] = (wcnt[s] != drop[s]);
        i_last[s]  = (wcnt[s] == len[s] - 1);
        i_data[s*64 +: 64] = pat(s, wcnt[s]);
        wcnt[s] = wcnt[s] + 1;
      end else begin
        i_valid[s] = 1'b0;
        i_last[s]  = 1'b0;
        wcnt[s]    = 0;
      end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] d, input logic [7:0] c);
    chk({tag, "_data"}, o_tx_data, d);
    chk({tag, "_ctrl"}, 64'(o_tx_ctrl), 64'(c));
  endtask

  initial begin
    tick();
    tick();
    chk_word("reset", IDLE_W, 8'hFF);
    chk("reset_grant", 64'(o_grant), 64'h0);
    chk("reset_busy", 64'(o_busy), 64'h0);
    chk("reset_underrun", 64'(o_underrun), 64'h0);

    // src0, 8 words, last carries 4 bytes
    len[0] = 8; i_last_nbytes[3:0] = 4'd4;
    i_rst_n = 1'b1; i_req = 2'b01;
    tick();
    chk("t1_grant", 64'(o_grant), 64'h1);
    chk("t1_busy", 64'(o_busy), 64'h1);
    chk_word("t1_idle", IDLE_W, 8'hFF);
    i_req = 2'b00;
    tick();
    chk_word("t1_start", START_W, 8'h01);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_word("t1_word", pat(0, k), 8'h00);
    end
    tick();
    chk_word("t1_last", pat_last(0, 7, 4), 8'hF0);
    chk("t1_grant_clr", 64'(o_grant), 64'h0);
    len[1] = 2; i_last_nbytes[7:4] = 4'd8; i_req = 2'b10;
    tick();
    chk_word("t1_gap1", IDLE_W, 8'hFF);
    chk("t1_gap1_grant", 64'(o_grant), 64'h0);
    tick();
    chk_word("t1_gap2", IDLE_W, 8'hFF);
    chk("t2_grant", 64'(o_grant), 64'h2);
    i_req = 2'b00;

    // src1, last word full, then TERM word
    tick();
    chk_word("t2_start", START_W, 8'h01);
    tick();
    chk_word("t2_w0", pat(1, 0), 8'h00);
    tick();
    chk_word("t2_w1", pat(1, 1), 8'h00);
    len[0] = 2; i_last_nbytes[3:0] = 4'd8; i_req = 2'b11;
    tick();
    chk_word("t2_term", TERM_W, 8'hFF);
    chk("t2_grant_clr", 64'(o_grant), 64'h0);

    // both requesting: grants alternate, one idle word after each TERM
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_grant", 64'(o_grant), 64'(1 << (i % 2)));
      chk_word("t3_idle", IDLE_W, 8'hFF);
      tick();
      chk_word("t3_start", START_W, 8'h01);
      tick();
      chk_word("t3_w0", pat(i % 2, 0), 8'h00);
      tick();
      chk_word("t3_w1", pat(i % 2, 1), 8'h00);
      tick();
      chk_word("t3_term", TERM_W, 8'hFF);
    end

    // underrun on third data cycle
    len[0] = 5; drop[0] = 2; i_req = 2'b01;
    tick();
    chk("t4_grant", 64'(o_grant), 64'h1);
    i_req = 2'b00;
    tick();
    chk_word("t4_start", START_W, 8'h01);
    tick();
    chk_word("t4_w0", pat(0, 0), 8'h00);
    tick();
    chk_word("t4_w1", pat(0, 1), 8'h00);
    tick();
    chk_word("t4_err", ERR_W, 8'hFF);
    chk("t4_underrun", 64'(o_underrun), 64'h1);
    chk("t4_grant_clr", 64'(o_grant), 64'h0);
    drop[0] = -1; len[1] = 6; i_req = 2'b10;
    tick();
    chk_word("t4_gap1", IDLE_W, 8'hFF);
    chk("t4_underrun_pulse", 64'(o_underrun), 64'h0);
    chk("t4_gap1_grant", 64'(o_grant), 64'h0);
    tick();
    chk_word("t4_gap2", IDLE_W, 8'hFF);
    chk("t4_regrant", 64'(o_grant), 64'h2);
    i_req = 2'b00;
    tick();
    chk_word("t4_start", START_W, 8'h01);

    // reset in the middle of a src1 frame
    tick();
    chk_word("t5_w0", pat(1, 0), 8'h00);
    tick();
    chk_word("t5_w1", pat(1, 1), 8'h00);
`ifdef MII_TX_STATS_EN
    chk("t6_frames", 64'(frame_cnt), 64'd6);
    chk("t6_aborts", 64'(abort_cnt), 64'd1);
`endif
    i_rst_n = 1'b0;
    tick();
    chk_word("t5_rst", IDLE_W, 8'hFF);
    chk("t5_rst_grant", 64'(o_grant), 64'h0);
    chk("t5_rst_busy", 64'(o_busy), 64'h0);
    i_rst_n = 1'b1; i_req = 2'b01; len[0] = 1; i_last_nbytes[3:0] = 4'd3;
    tick();
    chk("t5_grant", 64'(o_grant), 64'h1);
    chk_word("t5_idle", IDLE_W, 8'hFF);
    i_req = 2'b00;
    tick();
    chk_word("t5_start", START_W, 8'h01);
    tick();
    chk_word("t5_last3", pat_last(0, 0, 3), 8'hF8);
    chk("t5_busy_end", 64'(o_busy), 64'h0);
`ifdef MII_TX_STATS_EN
    chk("t6_frames_rst", 64'(frame_cnt), 64'd1);
    chk("t6_aborts_rst", 64'(abort_cnt), 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
